sim_mem_arbiter: RTL

SIM_MEM_ARBITER -- requirements
Module: sim_mem_arbiter

---
 rtl/sim_mem_arbiter.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/sim_mem_arbiter.sv
// sim_mem_arbiter
//   Round-robin arbiter that lets NUM_CH requesters share a single simulation
//   RAM port. Only one transaction is in flight at a time. A command is
//   accepted in IDLE and drives the RAM in that same cycle. The response is
//   presented LATENCY cycles later and is held until the owning channel
//   accepts it.
//
// Ports
//   clock, reset        : clock; synchronous active-high reset
//   ch_cmd_valid/ready  : per-channel command handshake (ready is combinational)
//   ch_cmd_addr         : NUM_CH x 64-bit byte address, channel i at [64i+63:64i]
//   ch_cmd_wen          : per-channel write enable (1 = write)
//   ch_cmd_wdata/wstrb  : NUM_CH x 64-bit write data / NUM_CH x 8-bit byte strobes
//   ch_rsp_valid/ready  : per-channel response handshake (at most one valid bit)
//   ch_rsp_data/err     : shared response data / out-of-window flag
//   ram_en, ram_idx     : RAM access enable and 64-bit word index
//   ram_rdata           : RAM read data, combinational from ram_idx
//   ram_wen/wdata/wmask : RAM write enable, data and per-bit write mask
module sim_mem_arbiter #(
  parameter int          NUM_CH    = 2,
  parameter int          LATENCY   = 1,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter int          IDX_W     = 28
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_CH-1:0]     ch_cmd_valid,
  output logic [NUM_CH-1:0]     ch_cmd_ready,
  input  logic [NUM_CH*64-1:0]  ch_cmd_addr,
  input  logic [NUM_CH-1:0]     ch_cmd_wen,
  input  logic [NUM_CH*64-1:0]  ch_cmd_wdata,
  input  logic [NUM_CH*8-1:0]   ch_cmd_wstrb,
  output logic [NUM_CH-1:0]     ch_rsp_valid,
  input  logic [NUM_CH-1:0]     ch_rsp_ready,
  output logic [63:0]           ch_rsp_data,
  output logic                  ch_rsp_err,
  output logic                  ram_en,
  output logic [IDX_W-1:0]      ram_idx,
  input  logic [63:0]           ram_rdata,
  output logic                  ram_wen,
  output logic [63:0]           ram_wdata,
  output logic [63:0]           ram_wmask
);

  localparam int         CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
  localparam bit         LAT_IS_ONE = (LATENCY == 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Each write-strobe bit covers one byte lane of the 64-bit word.
  function automatic logic [63:0] expand_strb(input logic [7:0] strb);
    logic [63:0] mask;
    mask = 64'd0;
    for (int b = 0; b < 8; b++) begin
      mask[b*8 +: 8] = {8{strb[b]}};
    end
    return mask;
  endfunction

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [CH_W-1:0]   rr_q, rr_d;
  logic [CH_W-1:0]   gnt_q, gnt_d;
  logic [63:0]       rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;

  logic [63:0]       addr_a  [NUM_CH];
  logic [63:0]       wdata_a [NUM_CH];
  logic [7:0]        wstrb_a [NUM_CH];

  logic              found_s;
  logic [CH_W-1:0]   sel_s;
  logic [CH_W-1:0]   cand_s;
  logic              accept_s;
  logic [63:0]       cmd_addr_s;
  logic [63:0]       off_s;
  logic              in_win_s;
  logic              cmd_wen_s;

  // Split the flat per-channel buses into arrays indexed by channel number.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      addr_a[i]  = ch_cmd_addr[i*64 +: 64];
      wdata_a[i] = ch_cmd_wdata[i*64 +: 64];
      wstrb_a[i] = ch_cmd_wstrb[i*8 +: 8];
    end
  end

  // Round-robin search. The search starts one channel after the last
  // accepted channel and wraps around.
  always_comb begin
    found_s = 1'b0;
    sel_s   = {CH_W{1'b0}};
    cand_s  = {CH_W{1'b0}};
    for (int k = 1; k <= NUM_CH; k++) begin
      cand_s = CH_W'((int'(rr_q) + k) % NUM_CH);
      if (!found_s && ch_cmd_valid[cand_s]) begin
        found_s = 1'b1;
        sel_s   = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Decode the address of the selected command against the RAM window.
  always_comb begin
    cmd_addr_s = addr_a[sel_s];
    cmd_wen_s  = ch_cmd_wen[sel_s];
    off_s      = cmd_addr_s - BASE_ADDR;
    // The lower bound is checked on the raw address. Addresses below the
    // base wrap to a huge offset, so the offset check alone is not enough.
    in_win_s   = (cmd_addr_s >= BASE_ADDR) && ((off_s >> (IDX_W + 3)) == 64'd0);
    accept_s   = (state_q == S_IDLE) && found_s && !reset;
  end

  // Next-state logic, command-side and RAM-side outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rr_d         = rr_q;
    gnt_d        = gnt_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    ch_cmd_ready = {NUM_CH{1'b0}};
    ram_en       = 1'b0;
    ram_idx      = {IDX_W{1'b0}};
    ram_wen      = 1'b0;
    ram_wdata    = 64'd0;
    ram_wmask    = 64'd0;

    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          ch_cmd_ready[sel_s] = 1'b1;
          rr_d  = sel_s;
          gnt_d = sel_s;
          if (in_win_s) begin
            ram_en     = 1'b1;
            ram_idx    = off_s[IDX_W+2:3];
            ram_wen    = cmd_wen_s;
            ram_wdata  = wdata_a[sel_s];
            ram_wmask  = expand_strb(wstrb_a[sel_s]);
            rsp_data_d = cmd_wen_s ? 64'd0 : ram_rdata;
            rsp_err_d  = 1'b0;
          end else begin
            rsp_data_d = 64'd0;
            rsp_err_d  = 1'b1;
          end
          if (LAT_IS_ONE) begin
            state_d = S_RESP;
            cnt_d   = 4'd0;
          end else begin
            state_d = S_WAIT;
            cnt_d   = LAT_M1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        // A count of 1 means the response becomes visible on the next cycle.
        if (cnt_q <= 4'd1) begin
          state_d = S_RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d   = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (ch_rsp_ready[gnt_q]) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Response outputs are decoded from registered state only.
  always_comb begin
    ch_rsp_valid = {NUM_CH{1'b0}};
    ch_rsp_data  = 64'd0;
    ch_rsp_err   = 1'b0;
    if ((state_q == S_RESP) && !reset) begin
      ch_rsp_valid[gnt_q] = 1'b1;
      ch_rsp_data         = rsp_data_q;
      ch_rsp_err          = rsp_err_q;
    end else begin
      ch_rsp_valid = {NUM_CH{1'b0}};
    end
  end

  // State, counter, round-robin pointer and response registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      rr_q       <= CH_W'(NUM_CH - 1);
      gnt_q      <= {CH_W{1'b0}};
      rsp_data_q <= 64'd0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rr_q       <= rr_d;
      gnt_q      <= gnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

endmodule
